// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: decodes MUL/DIV requests from the core, issues them to one of two
// coprocessor slots over a shared operand bus, mirrors the wait handshake, registers the
// result, and traps on undecoded instructions or a coprocessor that never answers.
module pcpi_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        pcpi_trap,
    output logic [31:0] co_insn,
    output logic [31:0] co_rs1,
    output logic [31:0] co_rs2,
    output logic        co0_valid,
    output logic        co1_valid,
    input  logic        co0_wr,
    input  logic [31:0] co0_rd,
    input  logic        co0_wait,
    input  logic        co0_ready,
    input  logic        co1_wr,
    input  logic [31:0] co1_rd,
    input  logic        co1_wait,
    input  logic        co1_ready
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    localparam logic [7:0] TcntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        seen_wait_q, seen_wait_d;
    logic        sel_q, sel_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        valid0_q, valid0_d;
    logic        valid1_q, valid1_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        wait_q, wait_d;
    logic        ready_q, ready_d;
    logic        trap_q, trap_d;

    logic        dec_hit;
    logic        sel_wait;
    logic        sel_ready;
    logic        sel_wr;
    logic [31:0] sel_rd;

    // Decode the incoming request and steer the selected slot's response.
    always_comb begin
        dec_hit   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
        sel_wait  = sel_q ? co1_wait  : co0_wait;
        sel_ready = sel_q ? co1_ready : co0_ready;
        sel_wr    = sel_q ? co1_wr    : co0_wr;
        sel_rd    = sel_q ? co1_rd    : co0_rd;
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        seen_wait_d = seen_wait_q;
        sel_d       = sel_q;
        insn_d      = insn_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        rd_d        = rd_q;
        wr_d        = 1'b0;
        wait_d      = 1'b0;
        ready_d     = 1'b0;
        trap_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (pcpi_valid) begin
                    insn_d      = pcpi_insn;
                    rs1_d       = pcpi_rs1;
                    rs2_d       = pcpi_rs2;
                    sel_d       = pcpi_insn[14];
                    tcnt_d      = 8'd0;
                    seen_wait_d = 1'b0;
                    if (dec_hit) begin
                        state_d  = StIssue;
                        valid0_d = ~pcpi_insn[14];
                        valid1_d = pcpi_insn[14];
                    end else begin
                        state_d = StDone;
                        trap_d  = 1'b1;
                    end
                end
            end
            StIssue: begin
                wait_d = sel_wait;
                if (sel_wait) begin
                    seen_wait_d = 1'b1;
                end
                // Ready beats both wait and the final timeout cycle.
                if (sel_ready) begin
                    rd_d     = sel_rd;
                    wr_d     = sel_wr;
                    ready_d  = 1'b1;
                    wait_d   = 1'b0;
                    valid0_d = 1'b0;
                    valid1_d = 1'b0;
                    state_d  = StDone;
                end else if (!seen_wait_q && !sel_wait && (tcnt_q == TcntLast)) begin
                    trap_d   = 1'b1;
                    wait_d   = 1'b0;
                    valid0_d = 1'b0;
                    valid1_d = 1'b0;
                    state_d  = StDone;
                end else if (!seen_wait_q) begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            StDone: begin
                valid0_d = 1'b0;
                valid1_d = 1'b0;
                // A held request is never reissued; wait for the core to drop it.
                if (!pcpi_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                valid0_d = 1'b0;
                valid1_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            tcnt_q      <= 8'd0;
            seen_wait_q <= 1'b0;
            sel_q       <= 1'b0;
            insn_q      <= 32'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            rd_q        <= 32'd0;
            wr_q        <= 1'b0;
            wait_q      <= 1'b0;
            ready_q     <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            seen_wait_q <= seen_wait_d;
            sel_q       <= sel_d;
            insn_q      <= insn_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wait_q      <= wait_d;
            ready_q     <= ready_d;
            trap_q      <= trap_d;
        end
    end

    assign pcpi_wr    = wr_q;
    assign pcpi_rd    = rd_q;
    assign pcpi_wait  = wait_q;
    assign pcpi_ready = ready_q;
    assign pcpi_trap  = trap_q;
    assign co_insn    = insn_q;
    assign co_rs1     = rs1_q;
    assign co_rs2     = rs2_q;
    assign co0_valid  = valid0_q;
    assign co1_valid  = valid1_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Self-checking bench for pcpi_dispatch: a request-level model predicts every output each
// cycle, directed scenarios pin exact latencies, and randomized requests cover the rest.
module tb_pcpi_dispatch;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_trap;
    logic [31:0] pcpi_rd, co_insn, co_rs1, co_rs2;
    logic        co0_valid, co1_valid;
    logic        co0_wr, co0_wait, co0_ready, co1_wr, co1_wait, co1_ready;
    logic [31:0] co0_rd, co1_rd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pcpi_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .pcpi_trap(pcpi_trap),
        .co_insn(co_insn), .co_rs1(co_rs1), .co_rs2(co_rs2),
        .co0_valid(co0_valid), .co1_valid(co1_valid),
        .co0_wr(co0_wr), .co0_rd(co0_rd), .co0_wait(co0_wait), .co0_ready(co0_ready),
        .co1_wr(co1_wr), .co1_rd(co1_rd), .co1_wait(co1_wait), .co1_ready(co1_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
    endfunction

    function automatic logic [31:0] ctrl_vec();
        return {26'd0, pcpi_wr, pcpi_wait, pcpi_ready, pcpi_trap, co0_valid, co1_valid};
    endfunction

    // Request-level model: phase 0 idle, 1 outstanding, 2 completed and awaiting valid drop.
    int          phase = 0;
    int          start = 0;
    bit          slot = 1'b0, waited = 1'b0;
    logic        e_wr, e_wait, e_ready, e_trap, e_v0, e_v1;
    logic [31:0] e_rd, e_insn, e_rs1, e_rs2;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            phase = 0;
            {e_wr, e_wait, e_ready, e_trap, e_v0, e_v1} = 6'd0;
            e_rd = 32'd0; e_insn = 32'd0; e_rs1 = 32'd0; e_rs2 = 32'd0;
        end else begin
            {e_wr, e_wait, e_ready, e_trap} = 4'd0;
            if (phase == 0) begin
                if (pcpi_valid) begin
                    e_insn = pcpi_insn; e_rs1 = pcpi_rs1; e_rs2 = pcpi_rs2;
                    if (is_hit(pcpi_insn)) begin
                        phase = 1; slot = pcpi_insn[14]; start = cyc; waited = 1'b0;
                        e_v0 = !slot; e_v1 = slot;
                    end else begin
                        phase = 2; e_trap = 1'b1;
                    end
                end
            end else if (phase == 1) begin
                if (slot ? co1_ready : co0_ready) begin
                    e_rd = slot ? co1_rd : co0_rd;
                    e_wr = slot ? co1_wr : co0_wr;
                    e_ready = 1'b1; e_v0 = 1'b0; e_v1 = 1'b0; phase = 2;
                end else if (!waited && !(slot ? co1_wait : co0_wait)
                             && (cyc - start == int'(TO))) begin
                    e_trap = 1'b1; e_v0 = 1'b0; e_v1 = 1'b0; phase = 2;
                end else begin
                    e_wait = slot ? co1_wait : co0_wait;
                    if (e_wait) waited = 1'b1;
                end
            end else begin
                e_v0 = 1'b0; e_v1 = 1'b0;
                if (!pcpi_valid) phase = 0;
            end
        end
        #1;
        chk("ctrl", ctrl_vec(), {26'd0, e_wr, e_wait, e_ready, e_trap, e_v0, e_v1});
        chk("pcpi_rd", pcpi_rd, e_rd);
        chk("co_insn", co_insn, e_insn);
        chk("co_rs1", co_rs1, e_rs1);
        chk("co_rs2", co_rs2, e_rs2);
    end

    task automatic zero_co();
        co0_wr = 1'b0; co0_rd = 32'd0; co0_wait = 1'b0; co0_ready = 1'b0;
        co1_wr = 1'b0; co1_rd = 32'd0; co1_wait = 1'b0; co1_ready = 1'b0;
    endtask

    // Issue one request and play a mock coprocessor; times t are edges counted from E=1.
    task automatic do_req(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                          input int wf, input int wt, input int ra, input logic [31:0] rdv,
                          input logic wrv, input int hold, input bit sp,
                          output int t_ready, output int t_trap, output logic [31:0] rd_seen,
                          output logic [1:0] v_first, output int n_ready, output int n_vhold);
        int  e;
        int  idx;
        bit  fin;
        logic w_on, r_on;
        t_ready = -1; t_trap = -1; rd_seen = 32'd0; v_first = 2'b00;
        n_ready = 0; n_vhold = 0; fin = 1'b0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
        e = cyc + 1;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            idx = cyc - e;
            if (k == 0) v_first = {co1_valid, co0_valid};
            if (pcpi_ready) begin
                n_ready++;
                if (t_ready < 0) begin t_ready = idx + 1; rd_seen = pcpi_rd; end
            end
            if (pcpi_trap && t_trap < 0) t_trap = idx + 1;
            if (pcpi_ready || pcpi_trap) begin
                fin = 1'b1;
                zero_co();
            end else begin
                w_on = (idx >= wf) && (idx < wt);
                r_on = (idx == ra);
                if (!insn[14]) begin
                    co0_wait = w_on; co0_ready = r_on; co0_rd = rdv; co0_wr = wrv;
                    co1_wait = sp ? 1'($urandom_range(0, 1)) : 1'b0;
                    co1_ready = sp; co1_rd = 32'd99; co1_wr = sp;
                end else begin
                    co1_wait = w_on; co1_ready = r_on; co1_rd = rdv; co1_wr = wrv;
                    co0_wait = sp ? 1'($urandom_range(0, 1)) : 1'b0;
                    co0_ready = sp; co0_rd = 32'd99; co0_wr = sp;
                end
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL req_done: no ready/trap within 300 cycles, insn %h", insn);
            zero_co();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (pcpi_ready) n_ready++;
            if (co0_valid || co1_valid) n_vhold++;
        end
        pcpi_valid = 1'b0;
        @(negedge clk);
        if (pcpi_ready) n_ready++;
    endtask

    int          tr, tt, nr, nv;
    logic [31:0] rs;
    logic [1:0]  vf;

    initial begin
        resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'd0; pcpi_rs1 = 32'd0;
        pcpi_rs2 = 32'd0;
        zero_co();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", ctrl_vec(), 32'd0);
        chk("rst_rd", pcpi_rd, 32'd0);

        // MUL route: three wait cycles then ready with 42.
        do_req(32'h02B50533, 32'd7, 32'd6, 0, 3, 3, 32'd42, 1'b1, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("mul_vfirst", {30'd0, vf}, 32'd1);
        chk("mul_tready", tr, 32'd5);
        chk("mul_rd", rs, 32'd42);
        chk("mul_npulse", nr, 32'd1);
        chk("mul_notrap", tt, 32'hFFFFFFFF);

        // DIV route with a noisy unselected slot 0.
        do_req(32'h02B54533, 32'd20, 32'd4, 1, 3, 4, 32'd5, 1'b1, 0, 1'b1,
               tr, tt, rs, vf, nr, nv);
        chk("div_vfirst", {30'd0, vf}, 32'd2);
        chk("div_rd", rs, 32'd5);
        chk("div_tready", tr, 32'd6);

        // Illegal: add.
        do_req(32'h00B50533, 32'd1, 32'd2, 0, 0, -1, 32'd0, 1'b0, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("ill_ttrap", tt, 32'd1);
        chk("ill_vfirst", {30'd0, vf}, 32'd0);
        chk("ill_noready", nr, 32'd0);

        // Silent coprocessor times out.
        do_req(32'h02B50533, 32'd3, 32'd3, 0, 0, -1, 32'd0, 1'b0, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("to_ttrap", tt, 32'd17);
        chk("to_noready", nr, 32'd0);

        // Early wait disables the timeout; late ready completes.
        do_req(32'h02B50533, 32'd9, 32'd9, 2, 3, 40, 32'd81, 1'b1, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("lw_tready", tr, 32'd42);
        chk("lw_notrap", tt, 32'hFFFFFFFF);

        // Ready in the final timeout cycle wins.
        do_req(32'h02B54533, 32'd8, 32'd2, 0, 0, 15, 32'd4, 1'b1, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("edge_tready", tr, 32'd17);
        chk("edge_notrap", tt, 32'hFFFFFFFF);

        // Wait only in the final timeout cycle also suppresses the trap.
        do_req(32'h02B50533, 32'd1, 32'd1, 15, 16, 20, 32'd1, 1'b0, 0, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("lastw_notrap", tt, 32'hFFFFFFFF);
        chk("lastw_tready", tr, 32'd22);

        // Held valid after completion: no reissue.
        do_req(32'h02B50533, 32'd2, 32'd5, 0, 0, 2, 32'd10, 1'b1, 3, 1'b0,
               tr, tt, rs, vf, nr, nv);
        chk("hold_npulse", nr, 32'd1);
        chk("hold_novalid", nv, 32'd0);

        // Reset in the middle of an outstanding MUL.
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6;
        repeat (3) @(negedge clk);
        resetn = 1'b0; pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mrst_ctrl", ctrl_vec(), 32'd0);
        chk("mrst_rd", pcpi_rd, 32'd0);
        chk("mrst_insn", co_insn, 32'd0);
        co0_ready = 1'b1; co0_rd = 32'd123; co0_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_noready", {31'd0, pcpi_ready}, 32'd0);
        end
        zero_co();
        @(negedge clk);

        // Randomized requests against the model.
        for (int n = 0; n < 80; n++) begin
            int          kind, wf, wl, ra, hold;
            logic [31:0] ins;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                ins = $urandom;
                if (is_hit(ins)) ins[25] = ~ins[25];
            end else begin
                ins = {7'b0000001, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 7'b0110011};
            end
            wf = int'($urandom_range(0, 20));
            wl = (kind < 4) ? 0 : int'($urandom_range(1, 6));
            ra = (kind == 1) ? -1 : int'($urandom_range(0, 30));
            hold = int'($urandom_range(0, 3));
            do_req(ins, $urandom, $urandom, wf, wf + wl, ra, $urandom,
                   1'($urandom_range(0, 1)), hold, 1'($urandom_range(0, 1)),
                   tr, tt, rs, vf, nr, nv);
            chk("rnd_npulse", nr, (tr > 0) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
